llc_snoop_responder: RTL and testbench

- Responder side of the shared-bus snoop protocol for the 16 MB, 16-way LLC.
- Accepts one snooped bus operation at a time from another processor and looks up the addressed set in the LLC tag/MESI array.
- Drives the snoop result (HIT/HITM/NOHIT) and updates the line's MESI state.
- When required, issues L1 messages and a dirty-line writeback before accepting the next snoop.

---
 rtl/llc_snoop_responder_pkg.sv | 104 ++++++++++
 rtl/llc_snoop_responder_if.sv | 42 ++++
 rtl/llc_snoop_responder_way_match.sv | 29 ++
 rtl/llc_snoop_responder.sv | 118 +++++++++++
 tb/tb_llc_snoop_responder.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/llc_snoop_responder_pkg.sv
// Shared types for the LLC snoop responder: geometry, protocol enums and the
// snoop action table that maps (op, old MESI) to result, new MESI and follow-ups.
package llc_snoop_responder_pkg;

    localparam int ADDR_SIZE   = 32;
    localparam int LINE_SIZE   = 64;
    localparam int N_WAY       = 16;
    localparam int NUM_SETS    = 16384;
    localparam int OFFSET_SIZE = $clog2(LINE_SIZE);
    localparam int INDEX_SIZE  = $clog2(NUM_SETS);
    localparam int TAG_SIZE    = ADDR_SIZE - INDEX_SIZE - OFFSET_SIZE;
    localparam int WAY_W       = $clog2(N_WAY);
    localparam int LINE_ST_W   = 2 + TAG_SIZE;

    typedef enum logic [1:0] {
        MESI_I = 2'd0,
        MESI_S = 2'd1,
        MESI_E = 2'd2,
        MESI_M = 2'd3
    } mesi_e;

    typedef enum logic [1:0] {
        OP_READ       = 2'd0,
        OP_WRITE      = 2'd1,
        OP_INVALIDATE = 2'd2,
        OP_RWIM       = 2'd3
    } snoop_op_e;

    typedef enum logic [1:0] {
        RSLT_HIT   = 2'd0,
        RSLT_HITM  = 2'd1,
        RSLT_NOHIT = 2'd2
    } snoop_rslt_e;

    typedef enum logic [1:0] {
        L1_GETLINE        = 2'd0,
        L1_INVALIDATELINE = 2'd1,
        L1_EVICTLINE      = 2'd2
    } l1_msg_e;

    typedef struct packed {
        mesi_e                mesi;
        logic [TAG_SIZE-1:0]  tag;
    } line_st_t;

    // Follow-up mask bits, issued in this order: GET, then WB, then INV.
    localparam logic [2:0] FU_GET = 3'b001;
    localparam logic [2:0] FU_WB  = 3'b010;
    localparam logic [2:0] FU_INV = 3'b100;

    typedef struct packed {
        mesi_e        new_mesi;
        snoop_rslt_e  rslt;
        logic         upd;
        logic         err;
        logic [2:0]   fu;
    } snp_act_t;

    // A miss is presented as old == MESI_I.
    function automatic snp_act_t next_mesi(snoop_op_e op, mesi_e old);
        snp_act_t a;
        a.new_mesi = old;
        a.rslt     = RSLT_NOHIT;
        a.upd      = 1'b0;
        a.err      = 1'b0;
        a.fu       = 3'b000;
        case (op)
            OP_READ: begin
                if (old == MESI_M) begin
                    a.rslt     = RSLT_HITM;
                    a.new_mesi = MESI_S;
                    a.fu       = FU_GET | FU_WB;
                end else if (old != MESI_I) begin
                    a.rslt     = RSLT_HIT;
                    a.new_mesi = MESI_S;
                end
            end
            OP_WRITE: a.err = (old != MESI_I);
            OP_INVALIDATE: begin
                if (old == MESI_S) begin
                    a.rslt     = RSLT_HIT;
                    a.new_mesi = MESI_I;
                    a.fu       = FU_INV;
                end else if (old != MESI_I) begin
                    a.err = 1'b1;
                end
            end
            default: begin
                if (old == MESI_M) begin
                    a.rslt     = RSLT_HITM;
                    a.new_mesi = MESI_I;
                    a.fu       = FU_GET | FU_WB | FU_INV;
                end else if (old != MESI_I) begin
                    a.rslt     = RSLT_HIT;
                    a.new_mesi = MESI_I;
                    a.fu       = FU_INV;
                end
            end
        endcase
        a.upd = (a.new_mesi != old);
        return a;
    endfunction

endpackage

// File: rtl/llc_snoop_responder_if.sv
// Snoop request/result, tag-array, L1 message and writeback signals of the
// snoop responder; slave is the responder, master is its environment.
interface llc_snoop_responder_if;
    import llc_snoop_responder_pkg::*;

    logic                      snp_valid;
    logic                      snp_ready;
    snoop_op_e                 snp_op;
    logic [ADDR_SIZE-1:0]      snp_addr;
    logic                      arr_rd_en;
    logic [INDEX_SIZE-1:0]     arr_rd_idx;
    logic [N_WAY*LINE_ST_W-1:0] arr_rd_ways;
    logic                      arr_wr_en;
    logic [INDEX_SIZE-1:0]     arr_wr_idx;
    logic [WAY_W-1:0]          arr_wr_way;
    mesi_e                     arr_wr_mesi;
    logic                      snp_rslt_valid;
    snoop_rslt_e               snp_rslt;
    logic                      l1_msg_valid;
    l1_msg_e                   l1_msg;
    logic [ADDR_SIZE-1:0]      l1_msg_addr;
    logic                      l1_msg_ready;
    logic                      wb_valid;
    logic [ADDR_SIZE-1:0]      wb_addr;
    logic                      wb_ready;
    logic                      proto_err;

    modport slave (
        input  snp_valid, snp_op, snp_addr, arr_rd_ways, l1_msg_ready, wb_ready,
        output snp_ready, arr_rd_en, arr_rd_idx, arr_wr_en, arr_wr_idx, arr_wr_way,
               arr_wr_mesi, snp_rslt_valid, snp_rslt, l1_msg_valid, l1_msg,
               l1_msg_addr, wb_valid, wb_addr, proto_err
    );

    modport master (
        output snp_valid, snp_op, snp_addr, arr_rd_ways, l1_msg_ready, wb_ready,
        input  snp_ready, arr_rd_en, arr_rd_idx, arr_wr_en, arr_wr_idx, arr_wr_way,
               arr_wr_mesi, snp_rslt_valid, snp_rslt, l1_msg_valid, l1_msg,
               l1_msg_addr, wb_valid, wb_addr, proto_err
    );

endinterface

// File: rtl/llc_snoop_responder_way_match.sv
// Tag compare across all ways of one set; the lowest valid matching way wins.
module llc_snoop_responder_way_match
    import llc_snoop_responder_pkg::*;
(
    input  logic [N_WAY*LINE_ST_W-1:0] ways,
    input  logic [TAG_SIZE-1:0]        tag,
    output logic                       hit,
    output logic [WAY_W-1:0]           way,
    output mesi_e                      mesi
);

    line_st_t [N_WAY-1:0] lines;
    assign lines = ways;

    // Scan high to low so the last assignment is the lowest hitting way.
    always_comb begin
        hit  = 1'b0;
        way  = '0;
        mesi = MESI_I;
        for (int w = N_WAY - 1; w >= 0; w--) begin
            if (lines[w].mesi != MESI_I && lines[w].tag == tag) begin
                hit  = 1'b1;
                way  = WAY_W'(w);
                mesi = lines[w].mesi;
            end
        end
    end

endmodule

// File: rtl/llc_snoop_responder.sv
// LLC snoop responder: look up one snooped op, report HIT/HITM/NOHIT, update
// MESI, then run any L1 messages and writeback before taking the next snoop.
//
//   state     | meaning
//   ----------+--------------------------------------------------
//   ST_IDLE   | ready for a snoop; accept issues the tag read
//   ST_LOOKUP | tag array data valid, compare and pick the action
//   ST_RESP   | result pulse and MESI write are on the outputs
//   ST_L1_GET | GETLINE to L1, wait for l1_msg_ready
//   ST_WB     | dirty line writeback, wait for wb_ready
//   ST_L1_INV | INVALIDATELINE to L1, wait for l1_msg_ready
module llc_snoop_responder
    import llc_snoop_responder_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    llc_snoop_responder_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOOKUP, ST_RESP, ST_L1_GET, ST_WB, ST_L1_INV
    } state_e;

    state_e                              state;
    state_e                              nxt;
    snoop_op_e                           op_q;
    logic [ADDR_SIZE-OFFSET_SIZE-1:0]    line_q;
    logic [2:0]                          fu_q;
    logic                                accept;
    logic                                m_hit;
    logic [WAY_W-1:0]                    m_way;
    mesi_e                               m_mesi;
    snp_act_t                            act_now;
    logic [ADDR_SIZE-1:0]                line_addr;

    assign accept         = bus.snp_valid && bus.snp_ready;
    assign bus.arr_rd_en  = accept;
    assign bus.arr_rd_idx = bus.snp_addr[OFFSET_SIZE +: INDEX_SIZE];
    assign line_addr      = {line_q, {OFFSET_SIZE{1'b0}}};

    llc_snoop_responder_way_match u_way_match (
        .ways (bus.arr_rd_ways),
        .tag  (line_q[ADDR_SIZE-OFFSET_SIZE-1 -: TAG_SIZE]),
        .hit  (m_hit),
        .way  (m_way),
        .mesi (m_mesi)
    );

    assign act_now = next_mesi(op_q, m_hit ? m_mesi : MESI_I);

    function automatic state_e follow(logic [2:0] fu);
        state_e s;
        if ((fu & FU_GET) != 3'b000)      s = ST_L1_GET;
        else if ((fu & FU_WB) != 3'b000)  s = ST_WB;
        else if ((fu & FU_INV) != 3'b000) s = ST_L1_INV;
        else                              s = ST_IDLE;
        return s;
    endfunction

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:   if (accept) nxt = ST_LOOKUP;
            ST_LOOKUP: nxt = ST_RESP;
            ST_RESP:   nxt = follow(fu_q);
            ST_L1_GET: if (bus.l1_msg_ready) nxt = follow(fu_q & (FU_WB | FU_INV));
            ST_WB:     if (bus.wb_ready) nxt = follow(fu_q & FU_INV);
            ST_L1_INV: if (bus.l1_msg_ready) nxt = ST_IDLE;
            default:   nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered as a function of the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= ST_IDLE;
            op_q               <= OP_READ;
            line_q             <= '0;
            fu_q               <= 3'b000;
            bus.snp_ready      <= 1'b1;
            bus.snp_rslt_valid <= 1'b0;
            bus.snp_rslt       <= RSLT_HIT;
            bus.arr_wr_en      <= 1'b0;
            bus.arr_wr_idx     <= '0;
            bus.arr_wr_way     <= '0;
            bus.arr_wr_mesi    <= MESI_I;
            bus.proto_err      <= 1'b0;
            bus.l1_msg_valid   <= 1'b0;
            bus.l1_msg         <= L1_GETLINE;
            bus.l1_msg_addr    <= '0;
            bus.wb_valid       <= 1'b0;
            bus.wb_addr        <= '0;
        end else begin
            state <= nxt;
            if (accept) begin
                op_q   <= bus.snp_op;
                line_q <= bus.snp_addr[ADDR_SIZE-1:OFFSET_SIZE];
            end
            if (state == ST_LOOKUP) fu_q <= act_now.fu;
            bus.snp_ready      <= (nxt == ST_IDLE);
            bus.snp_rslt_valid <= (nxt == ST_RESP);
            bus.snp_rslt       <= (nxt == ST_RESP) ? act_now.rslt : RSLT_HIT;
            bus.arr_wr_en      <= (nxt == ST_RESP) && act_now.upd;
            bus.proto_err      <= (nxt == ST_RESP) && act_now.err;
            if (nxt == ST_RESP) begin
                bus.arr_wr_idx  <= line_q[INDEX_SIZE-1:0];
                bus.arr_wr_way  <= m_way;
                bus.arr_wr_mesi <= act_now.new_mesi;
            end
            bus.l1_msg_valid <= (nxt == ST_L1_GET) || (nxt == ST_L1_INV);
            bus.l1_msg       <= (nxt == ST_L1_INV) ? L1_INVALIDATELINE : L1_GETLINE;
            bus.l1_msg_addr  <= line_addr;
            bus.wb_valid     <= (nxt == ST_WB);
            bus.wb_addr      <= line_addr;
        end
    end

endmodule

// File: tb/tb_llc_snoop_responder.sv
// Directed scoreboard bench for llc_snoop_responder: stimulus queues expected
// results, L1 messages and writebacks; a negedge monitor pops and compares.
module tb_llc_snoop_responder;
    import llc_snoop_responder_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    llc_snoop_responder_if bus();
    llc_snoop_responder dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        snoop_rslt_e      rslt;
        logic             wr;
        logic [WAY_W-1:0] way;
        mesi_e            mesi;
        logic             err;
        int               cyc;
    } rslt_exp_t;

    typedef struct {
        l1_msg_e     msg;
        logic [31:0] addr;
    } l1_exp_t;

    typedef struct {
        snoop_op_e   op;
        logic [31:0] addr;
        logic [13:0] idx;
        logic [31:0] line;
        int          wa;
        mesi_e       ma;
        logic [11:0] ta;
        int          wb2;
        mesi_e       mb;
        logic [11:0] tb;
        snoop_rslt_e rslt;
        logic        wr;
        int          wway;
        mesi_e       wmesi;
        logic        err;
        logic [2:0]  fu;
        int          lat;
        int          l1s;
        int          wbs;
    } vec_t;

    rslt_exp_t   rq[$];
    l1_exp_t     l1q[$];
    logic [31:0] wbq[$];
    vec_t        vecs[$];

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int l1_stall = 0;
    int wb_stall = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic vec_t mk(snoop_op_e op, logic [31:0] addr, logic [13:0] idx, logic [31:0] line,
                                int wa, mesi_e ma, logic [11:0] ta, int wb2, mesi_e mb, logic [11:0] tb,
                                snoop_rslt_e rslt, logic wr, int wway, mesi_e wmesi, logic err,
                                logic [2:0] fu, int lat, int l1s, int wbs);
        vec_t v;
        v.op = op; v.addr = addr; v.idx = idx; v.line = line;
        v.wa = wa; v.ma = ma; v.ta = ta; v.wb2 = wb2; v.mb = mb; v.tb = tb;
        v.rslt = rslt; v.wr = wr; v.wway = wway; v.wmesi = wmesi; v.err = err;
        v.fu = fu; v.lat = lat; v.l1s = l1s; v.wbs = wbs;
        return v;
    endfunction

    // Unused ways are invalid but carry the probe tag, so a valid bit is required to hit.
    task automatic set_ways(input vec_t v);
        line_st_t [N_WAY-1:0] lines;
        for (int w = 0; w < N_WAY; w++) begin
            lines[w].mesi = MESI_I;
            lines[w].tag  = v.addr[31:20];
        end
        if (v.wa >= 0) begin lines[v.wa].mesi = v.ma; lines[v.wa].tag = v.ta; end
        if (v.wb2 >= 0) begin lines[v.wb2].mesi = v.mb; lines[v.wb2].tag = v.tb; end
        bus.arr_rd_ways = lines;
    endtask

    // Called at a negedge with the responder idle.
    task automatic issue(input vec_t v, output int c0);
        rslt_exp_t r;
        l1_exp_t   m;
        bus.snp_op    = v.op;
        bus.snp_addr  = v.addr;
        bus.snp_valid = 1'b1;
        set_ways(v);
        l1_stall = v.l1s;
        wb_stall = v.wbs;
        c0 = cyc;
        #1;
        check(bus.snp_ready == 1'b1, "accept_ready", 32'(bus.snp_ready), 1);
        check(bus.arr_rd_en == 1'b1, "arr_rd_en", 32'(bus.arr_rd_en), 1);
        check(bus.arr_rd_idx == v.idx, "arr_rd_idx", 32'(bus.arr_rd_idx), 32'(v.idx));
        r.rslt = v.rslt; r.wr = v.wr; r.way = WAY_W'(v.wway); r.mesi = v.wmesi;
        r.err = v.err; r.cyc = c0 + 2;
        rq.push_back(r);
        if (v.fu[0]) begin m.msg = L1_GETLINE; m.addr = v.line; l1q.push_back(m); end
        if (v.fu[1]) wbq.push_back(v.line);
        if (v.fu[2]) begin m.msg = L1_INVALIDATELINE; m.addr = v.line; l1q.push_back(m); end
        @(posedge clk);
        #1;
        bus.snp_valid = 1'b0;
        bus.snp_op    = OP_RWIM;
        bus.snp_addr  = 32'hFFFF_FFFF;
    endtask

    task automatic wait_idle(input int exp_lat, input int c0);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.snp_ready && n < 60);
        check(bus.snp_ready && (cyc - c0) == exp_lat, "idle_latency", 32'(cyc - c0), 32'(exp_lat));
    endtask

    // Monitor: drives the ready inputs from the stall budgets, then checks outputs.
    initial begin
        rslt_exp_t r;
        l1_exp_t   m;
        forever begin
            @(negedge clk);
            bus.l1_msg_ready = (l1_stall == 0);
            if (bus.l1_msg_valid && l1_stall > 0) l1_stall--;
            bus.wb_ready = (wb_stall == 0);
            if (bus.wb_valid && wb_stall > 0) wb_stall--;
            check(!(bus.l1_msg_valid && bus.wb_valid), "l1_wb_exclusive",
                  {30'd0, bus.l1_msg_valid, bus.wb_valid}, 0);
            if (bus.snp_rslt_valid) begin
                if (rq.size() == 0) check(1'b0, "rslt_unexpected", 1, 0);
                else begin
                    r = rq.pop_front();
                    check(bus.snp_rslt == r.rslt, "snp_rslt", 32'(bus.snp_rslt), 32'(r.rslt));
                    check(cyc == r.cyc, "rslt_cycle", 32'(cyc), 32'(r.cyc));
                    check(bus.arr_wr_en == r.wr, "arr_wr_en", 32'(bus.arr_wr_en), 32'(r.wr));
                    check(bus.proto_err == r.err, "proto_err", 32'(bus.proto_err), 32'(r.err));
                    if (r.wr) begin
                        check(bus.arr_wr_way == r.way, "arr_wr_way", 32'(bus.arr_wr_way), 32'(r.way));
                        check(bus.arr_wr_mesi == r.mesi, "arr_wr_mesi", 32'(bus.arr_wr_mesi), 32'(r.mesi));
                    end
                end
            end else begin
                check(!bus.arr_wr_en && !bus.proto_err, "no_stray_wr_err",
                      {30'd0, bus.arr_wr_en, bus.proto_err}, 0);
            end
            if (bus.l1_msg_valid) begin
                if (l1q.size() == 0) check(1'b0, "l1_unexpected", 32'(bus.l1_msg), 0);
                else begin
                    m = l1q[0];
                    check(bus.l1_msg == m.msg, "l1_msg", 32'(bus.l1_msg), 32'(m.msg));
                    check(bus.l1_msg_addr == m.addr, "l1_msg_addr", bus.l1_msg_addr, m.addr);
                    if (bus.l1_msg_ready) void'(l1q.pop_front());
                end
            end
            if (bus.wb_valid) begin
                if (wbq.size() == 0) check(1'b0, "wb_unexpected", bus.wb_addr, 0);
                else begin
                    check(bus.wb_addr == wbq[0], "wb_addr", bus.wb_addr, wbq[0]);
                    if (bus.wb_ready) void'(wbq.pop_front());
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] A  = 32'h1234_5678;
    localparam logic [31:0] AL = 32'h1234_5640;
    localparam logic [31:0] B  = 32'hABCD_E0C0;

    initial begin
        int c0;
        int n;
        vec_t v;
        bus.snp_valid = 1'b0;
        bus.snp_op = OP_READ;
        bus.snp_addr = '0;
        bus.arr_rd_ways = '0;
        bus.l1_msg_ready = 1'b1;
        bus.wb_ready = 1'b1;
        repeat (2) @(negedge clk);
        check(bus.snp_ready == 1'b1, "reset_snp_ready", 32'(bus.snp_ready), 1);
        check({bus.snp_rslt_valid, bus.arr_wr_en, bus.l1_msg_valid, bus.wb_valid, bus.proto_err} == 5'b0,
              "reset_outputs", {27'd0, bus.snp_rslt_valid, bus.arr_wr_en, bus.l1_msg_valid,
              bus.wb_valid, bus.proto_err}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check(bus.snp_ready == 1'b1, "post_reset_ready", 32'(bus.snp_ready), 1);

        vecs.push_back(mk(OP_READ, A, 14'h1159, AL, 3, MESI_M, 12'h123, -1, MESI_I, 0,
                          RSLT_HITM, 1, 3, MESI_S, 0, 3'b011, 5, 0, 0));
        vecs.push_back(mk(OP_READ, A, 14'h1159, AL, 3, MESI_M, 12'h123, -1, MESI_I, 0,
                          RSLT_HITM, 1, 3, MESI_S, 0, 3'b011, 10, 2, 3));
        vecs.push_back(mk(OP_RWIM, A, 14'h1159, AL, 3, MESI_E, 12'h123, -1, MESI_I, 0,
                          RSLT_HIT, 1, 3, MESI_I, 0, 3'b100, 4, 0, 0));
        vecs.push_back(mk(OP_READ, A, 14'h1159, AL, -1, MESI_I, 0, -1, MESI_I, 0,
                          RSLT_NOHIT, 0, 0, MESI_I, 0, 3'b000, 3, 0, 0));
        vecs.push_back(mk(OP_READ, A, 14'h1159, AL, 3, MESI_M, 12'h124, -1, MESI_I, 0,
                          RSLT_NOHIT, 0, 0, MESI_I, 0, 3'b000, 3, 0, 0));
        vecs.push_back(mk(OP_INVALIDATE, A, 14'h1159, AL, 3, MESI_M, 12'h123, -1, MESI_I, 0,
                          RSLT_NOHIT, 0, 0, MESI_I, 1, 3'b000, 3, 0, 0));
        vecs.push_back(mk(OP_WRITE, A, 14'h1159, AL, 5, MESI_S, 12'h123, -1, MESI_I, 0,
                          RSLT_NOHIT, 0, 0, MESI_I, 1, 3'b000, 3, 0, 0));
        vecs.push_back(mk(OP_WRITE, A, 14'h1159, AL, -1, MESI_I, 0, -1, MESI_I, 0,
                          RSLT_NOHIT, 0, 0, MESI_I, 0, 3'b000, 3, 0, 0));
        vecs.push_back(mk(OP_INVALIDATE, A, 14'h1159, AL, 0, MESI_S, 12'h123, -1, MESI_I, 0,
                          RSLT_HIT, 1, 0, MESI_I, 0, 3'b100, 4, 0, 0));
        vecs.push_back(mk(OP_READ, A, 14'h1159, AL, 2, MESI_S, 12'h123, 7, MESI_S, 12'h123,
                          RSLT_HIT, 0, 0, MESI_I, 0, 3'b000, 3, 0, 0));
        vecs.push_back(mk(OP_RWIM, A, 14'h1159, AL, 2, MESI_S, 12'h123, 7, MESI_S, 12'h123,
                          RSLT_HIT, 1, 2, MESI_I, 0, 3'b100, 4, 0, 0));
        vecs.push_back(mk(OP_RWIM, B, 14'h3783, B, 15, MESI_M, 12'hABC, -1, MESI_I, 0,
                          RSLT_HITM, 1, 15, MESI_I, 0, 3'b111, 6, 0, 0));
        vecs.push_back(mk(OP_READ, B, 14'h3783, B, 9, MESI_E, 12'hABC, -1, MESI_I, 0,
                          RSLT_HIT, 1, 9, MESI_S, 0, 3'b000, 3, 0, 0));
        vecs.push_back(mk(OP_READ, B, 14'h3783, B, 4, MESI_E, 12'hABC, 1, MESI_M, 12'hABC,
                          RSLT_HITM, 1, 1, MESI_S, 0, 3'b011, 6, 1, 0));
        vecs.push_back(mk(OP_INVALIDATE, B, 14'h3783, B, 6, MESI_E, 12'hABC, -1, MESI_I, 0,
                          RSLT_NOHIT, 0, 0, MESI_I, 1, 3'b000, 3, 0, 0));

        // Each vector starts on the very negedge the previous one returned to idle.
        for (int i = 0; i < vecs.size(); i++) begin
            issue(vecs[i], c0);
            wait_idle(vecs[i].lat, c0);
        end

        // Reset while a writeback is stalled: pending WB and INVALIDATELINE are dropped.
        v = mk(OP_RWIM, A, 14'h1159, AL, 3, MESI_M, 12'h123, -1, MESI_I, 0,
               RSLT_HITM, 1, 3, MESI_I, 0, 3'b111, 0, 0, 1000);
        issue(v, c0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.wb_valid && n < 20);
        check(bus.wb_valid == 1'b1, "reset_wb_reached", 32'(bus.wb_valid), 1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check(bus.snp_ready == 1'b1, "midop_reset_ready", 32'(bus.snp_ready), 1);
        check({bus.snp_rslt_valid, bus.arr_wr_en, bus.l1_msg_valid, bus.wb_valid, bus.proto_err} == 5'b0,
              "midop_reset_outputs", {27'd0, bus.snp_rslt_valid, bus.arr_wr_en, bus.l1_msg_valid,
              bus.wb_valid, bus.proto_err}, 0);
        check(bus.wb_addr == 32'd0 && bus.l1_msg_addr == 32'd0, "midop_reset_addr",
              bus.wb_addr | bus.l1_msg_addr, 0);
        check(wbq.size() == 1 && l1q.size() == 1 && rq.size() == 0, "midop_pending",
              32'(wbq.size() * 16 + l1q.size() * 4 + rq.size()), 32'h14);
        wbq.delete();
        l1q.delete();
        wb_stall = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        v = mk(OP_READ, A, 14'h1159, AL, 3, MESI_E, 12'h123, -1, MESI_I, 0,
               RSLT_HIT, 1, 3, MESI_S, 0, 3'b000, 3, 0, 0);
        issue(v, c0);
        wait_idle(v.lat, c0);
        v = mk(OP_RWIM, A, 14'h1159, AL, 3, MESI_M, 12'h123, -1, MESI_I, 0,
               RSLT_HITM, 1, 3, MESI_I, 0, 3'b111, 6, 0, 0);
        issue(v, c0);
        wait_idle(v.lat, c0);

        repeat (2) @(negedge clk);
        check(rq.size() == 0, "rslt_queue_drained", 32'(rq.size()), 0);
        check(l1q.size() == 0, "l1_queue_drained", 32'(l1q.size()), 0);
        check(wbq.size() == 0, "wb_queue_drained", 32'(wbq.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
